// File: rtl/alu_modport.sv
// Registered ALU: one arithmetic/logical command per enabled clock, with a
// two-cycle multiply path sequenced by a small FSM.
module alu_modport #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 CE,
  input  logic [1:0]           INP_VALID,
  input  logic                 MODE,
  input  logic [CMD_WIDTH:0]   CMD,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic                 CIN,
  output logic [WIDTH:0]       RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 L,
  output logic                 E,
  output logic                 ERR
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_mul_res;

  logic [WIDTH:0]   w_a, w_b, w_cin, w_one;
  logic [WIDTH:0]   w_res;
  logic             w_cout, w_oflow, w_g, w_l, w_e, w_err, w_mul;
  logic             w_need_a, w_need_b, w_bad_cmd;
  logic [SHW-1:0]   w_sh;
  logic [2*WIDTH-1:0] w_rol2, w_ror2;
  logic [2*WIDTH+1:0] w_prod;

  logic             w_load;
  logic [WIDTH:0]   w_o_res;
  logic             w_o_cout, w_o_oflow, w_o_g, w_o_l, w_o_e, w_o_err;

  assign w_a   = {1'b0, OPA};
  assign w_b   = {1'b0, OPB};
  assign w_cin = {{WIDTH{1'b0}}, CIN};
  assign w_one = {{WIDTH{1'b0}}, 1'b1};
  assign w_sh  = OPB[SHW-1:0];

  always_comb begin
    w_res     = '0;
    w_cout    = 1'b0;
    w_oflow   = 1'b0;
    w_g       = 1'b0;
    w_l       = 1'b0;
    w_e       = 1'b0;
    w_err     = 1'b0;
    w_mul     = 1'b0;
    w_need_a  = 1'b1;
    w_need_b  = 1'b1;
    w_bad_cmd = 1'b0;
    w_prod    = '0;
    w_rol2    = {OPA, OPA} << w_sh;
    w_ror2    = {OPA, OPA} >> w_sh;
    if (MODE) begin
      case (int'(CMD))
        0: begin w_res = w_a + w_b;         w_cout  = w_res[WIDTH]; end
        1: begin w_res = w_a - w_b;         w_oflow = (OPA < OPB); end
        2: begin w_res = w_a + w_b + w_cin; w_cout  = w_res[WIDTH]; end
        3: begin w_res = w_a - w_b - w_cin; w_oflow = (w_a < (w_b + w_cin)); end
        4: begin w_need_b = 1'b0; w_res = w_a + w_one; w_cout  = w_res[WIDTH]; end
        5: begin w_need_b = 1'b0; w_res = w_a - w_one; w_oflow = (OPA == '0); end
        6: begin w_need_a = 1'b0; w_res = w_b + w_one; w_cout  = w_res[WIDTH]; end
        7: begin w_need_a = 1'b0; w_res = w_b - w_one; w_oflow = (OPB == '0); end
        8: begin w_g = (OPA > OPB); w_l = (OPA < OPB); w_e = (OPA == OPB); end
        9: begin
          w_mul  = 1'b1;
          w_prod = {{(WIDTH+1){1'b0}}, w_a + w_one} * {{(WIDTH+1){1'b0}}, w_b + w_one};
          w_res  = w_prod[WIDTH:0];
        end
        10: begin
          w_mul  = 1'b1;
          w_prod = {{(WIDTH+1){1'b0}}, OPA, 1'b0} * {{(WIDTH+1){1'b0}}, w_b};
          w_res  = w_prod[WIDTH:0];
        end
        default: w_bad_cmd = 1'b1;
      endcase
    end else begin
      case (int'(CMD))
        0:  w_res = {1'b0, OPA & OPB};
        1:  w_res = {1'b0, ~(OPA & OPB)};
        2:  w_res = {1'b0, OPA | OPB};
        3:  w_res = {1'b0, ~(OPA | OPB)};
        4:  w_res = {1'b0, OPA ^ OPB};
        5:  w_res = {1'b0, ~(OPA ^ OPB)};
        6:  begin w_need_b = 1'b0; w_res = {1'b0, ~OPA}; end
        7:  begin w_need_a = 1'b0; w_res = {1'b0, ~OPB}; end
        8:  begin w_need_b = 1'b0; w_res = {2'b00, OPA[WIDTH-1:1]}; end
        9:  begin w_need_b = 1'b0; w_res = {1'b0, OPA[WIDTH-2:0], 1'b0}; end
        10: begin w_need_a = 1'b0; w_res = {2'b00, OPB[WIDTH-1:1]}; end
        11: begin w_need_a = 1'b0; w_res = {1'b0, OPB[WIDTH-2:0], 1'b0}; end
        12: begin w_res = {1'b0, w_rol2[2*WIDTH-1:WIDTH]}; w_err = |(OPB >> SHW); end
        13: begin w_res = {1'b0, w_ror2[WIDTH-1:0]};       w_err = |(OPB >> SHW); end
        default: w_bad_cmd = 1'b1;
      endcase
    end
    // Missing operands or unknown commands override everything, including a multiply.
    if (w_bad_cmd || (w_need_a && !INP_VALID[0]) || (w_need_b && !INP_VALID[1])) begin
      w_res   = '0;
      w_cout  = 1'b0;
      w_oflow = 1'b0;
      w_g     = 1'b0;
      w_l     = 1'b0;
      w_e     = 1'b0;
      w_mul   = 1'b0;
      w_err   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)    r_state <= S_IDLE;
    else if (CE) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_mul ? S_MUL : S_IDLE;
      S_MUL:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The second multiply cycle publishes the stored product and drops the
  // command presented on that edge.
  always_comb begin
    w_load    = 1'b0;
    w_o_res   = '0;
    w_o_cout  = 1'b0;
    w_o_oflow = 1'b0;
    w_o_g     = 1'b0;
    w_o_l     = 1'b0;
    w_o_e     = 1'b0;
    w_o_err   = 1'b0;
    if (r_state == S_MUL) begin
      w_load  = 1'b1;
      w_o_res = r_mul_res;
    end else if (!w_mul) begin
      w_load    = 1'b1;
      w_o_res   = w_res;
      w_o_cout  = w_cout;
      w_o_oflow = w_oflow;
      w_o_g     = w_g;
      w_o_l     = w_l;
      w_o_e     = w_e;
      w_o_err   = w_err;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_mul_res <= '0;
    end else if (CE && r_state == S_IDLE && w_mul) begin
      r_mul_res <= w_res;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      RES   <= '0;
      COUT  <= 1'b0;
      OFLOW <= 1'b0;
      G     <= 1'b0;
      L     <= 1'b0;
      E     <= 1'b0;
      ERR   <= 1'b0;
    end else if (CE && w_load) begin
      RES   <= w_o_res;
      COUT  <= w_o_cout;
      OFLOW <= w_o_oflow;
      G     <= w_o_g;
      L     <= w_o_l;
      E     <= w_o_e;
      ERR   <= w_o_err;
    end
  end

endmodule

// File: tb/tb_alu_modport.sv
// Self-checking bench for alu_modport: directed scenarios plus randomized
// commands against an integer-arithmetic reference model.
module tb_alu_modport;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          RST, CE, MODE, CIN;
  logic [1:0]    INP_VALID;
  logic [CW:0]   CMD;
  logic [W-1:0]  OPA, OPB;
  logic [W:0]    RES;
  logic          COUT, OFLOW, G, L, E, ERR;

  always #5 clk = ~clk;

  alu_modport #(.WIDTH(W), .CMD_WIDTH(CW)) dut (
    .clk(clk), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
    .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
  );

  typedef struct {
    int res;
    bit cout, oflow, g, l, e, err, is_mul;
  } exp_t;

  exp_t exp_q;
  bit   pend;
  int   pend_val;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic exp_t zero_exp();
    exp_t r;
    r.res = 0; r.cout = 0; r.oflow = 0; r.g = 0; r.l = 0; r.e = 0; r.err = 0; r.is_mul = 0;
    return r;
  endfunction

  // Behavioural reference: outcome of one command, from the arithmetic rules.
  function automatic exp_t ref_model(bit mode, int cmd, int a, int b, bit cin, bit [1:0] iv);
    exp_t r = zero_exp();
    int m  = (1 << (W + 1)) - 1;
    int wm = (1 << W) - 1;
    int need;
    int v;
    int s;
    if (mode) begin
      if (cmd > 10) begin r.err = 1; return r; end
      need = (cmd == 4 || cmd == 5) ? 1 : (cmd == 6 || cmd == 7) ? 2 : 3;
    end else begin
      if (cmd > 13) begin r.err = 1; return r; end
      need = (cmd == 6 || cmd == 8 || cmd == 9) ? 1 : (cmd == 7 || cmd == 10 || cmd == 11) ? 2 : 3;
    end
    if ((need == 1 && !iv[0]) || (need == 2 && !iv[1]) || (need == 3 && iv != 2'b11)) begin
      r.err = 1; return r;
    end
    if (mode) begin
      case (cmd)
        0: begin v = a + b;       r.res = v & m; r.cout  = v > wm; end
        1: begin v = a - b;       r.res = v & m; r.oflow = v < 0;  end
        2: begin v = a + b + cin; r.res = v & m; r.cout  = v > wm; end
        3: begin v = a - b - cin; r.res = v & m; r.oflow = v < 0;  end
        4: begin v = a + 1;       r.res = v & m; r.cout  = v > wm; end
        5: begin v = a - 1;       r.res = v & m; r.oflow = v < 0;  end
        6: begin v = b + 1;       r.res = v & m; r.cout  = v > wm; end
        7: begin v = b - 1;       r.res = v & m; r.oflow = v < 0;  end
        8: begin r.g = a > b; r.l = a < b; r.e = a == b; end
        9: begin r.res = ((a + 1) * (b + 1)) & m; r.is_mul = 1; end
        default: begin r.res = ((a * 2) * b) & m; r.is_mul = 1; end
      endcase
    end else begin
      s = b % W;
      case (cmd)
        0:  r.res = a & b;
        1:  r.res = ~(a & b) & wm;
        2:  r.res = a | b;
        3:  r.res = ~(a | b) & wm;
        4:  r.res = a ^ b;
        5:  r.res = ~(a ^ b) & wm;
        6:  r.res = ~a & wm;
        7:  r.res = ~b & wm;
        8:  r.res = a >> 1;
        9:  r.res = (a << 1) & wm;
        10: r.res = b >> 1;
        11: r.res = (b << 1) & wm;
        12: begin r.res = ((a << s) | (a >> (W - s))) & wm; r.err = b >= W; end
        default: begin r.res = ((a >> s) | (a << (W - s))) & wm; r.err = b >= W; end
      endcase
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".res"}, 32'(RES), 32'(exp_q.res));
    check_val({tag, ".flags(co,of,g,l,e,err)"}, 32'({COUT, OFLOW, G, L, E, ERR}),
              32'({exp_q.cout, exp_q.oflow, exp_q.g, exp_q.l, exp_q.e, exp_q.err}));
  endtask

  task automatic drive(input bit ce, input bit mode, input int cmd, input int a, input int b,
                       input bit cin, input bit [1:0] iv);
    CE = ce; MODE = mode; CMD = (CW+1)'(cmd); OPA = W'(a); OPB = W'(b); CIN = cin; INP_VALID = iv;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic cycle(input string tag);
    exp_t r;
    @(posedge clk);
    if (RST && CE) begin
      if (pend) begin
        exp_q = zero_exp();
        exp_q.res = pend_val;
        pend = 0;
      end else begin
        r = ref_model(MODE, int'(CMD), int'(OPA), int'(OPB), CIN, INP_VALID);
        if (r.is_mul) begin
          pend = 1;
          pend_val = r.res;
        end else begin
          exp_q = r;
        end
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    exp_q = zero_exp();
    pend = 0;
    pend_val = 0;
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    #12;
    check_outputs("reset");
    @(posedge clk); #1;
    RST = 1'b1;

    drive(1, 1, 2, 'hFF, 'h01, 1, 2'b11);
    cycle("add_cin");
    check_val("add_cin.const", 32'({COUT, ERR, RES}), 32'({1'b1, 1'b0, 9'h101}));

    drive(1, 1, 1, 'h05, 'h0A, 0, 2'b11);
    cycle("sub_borrow");
    check_val("sub_borrow.const", 32'({OFLOW, RES}), 32'({1'b1, 9'h1FB}));

    drive(1, 1, 8, 'h3C, 'h3C, 0, 2'b11);
    cycle("cmp_eq");
    check_val("cmp_eq.const", 32'({G, L, E, RES}), 32'({3'b001, 9'h000}));
    drive(1, 1, 8, 'h40, 'h3C, 0, 2'b11);
    cycle("cmp_gt");

    drive(1, 1, 0, 'h10, 'h20, 0, 2'b11);
    cycle("add_pre_mul");
    drive(1, 1, 9, 3, 4, 0, 2'b11);
    cycle("mul_hold");
    check_val("mul_hold.const", 32'(RES), 32'h30);
    drive(1, 1, 0, 1, 1, 0, 2'b11);
    cycle("mul_result");
    check_val("mul_result.const", 32'(RES), 32'd20);

    drive(1, 1, 10, 5, 7, 0, 2'b11);
    cycle("mul2_capture");
    drive(0, 1, 0, 9, 9, 0, 2'b11);
    cycle("mul2_stall1");
    cycle("mul2_stall2");
    check_val("mul2_stall.const", 32'(RES), 32'd20);
    drive(1, 0, 4, 'hAA, 'h55, 0, 2'b11);
    cycle("mul2_result");
    check_val("mul2_result.const", 32'(RES), 32'd70);

    drive(1, 0, 12, 'h81, 'h01, 0, 2'b11);
    cycle("rol");
    check_val("rol.const", 32'({ERR, RES}), 32'({1'b0, 9'h003}));
    drive(1, 0, 12, 'h81, 'h11, 0, 2'b11);
    cycle("rol_err");
    check_val("rol_err.const", 32'({ERR, RES}), 32'({1'b1, 9'h003}));
    drive(1, 0, 0, 'hFF, 'hFF, 0, 2'b01);
    cycle("missing_b");
    check_val("missing_b.const", 32'({ERR, RES}), 32'({1'b1, 9'h000}));
    drive(1, 0, 15, 1, 2, 0, 2'b11);
    cycle("bad_cmd");
    check_val("bad_cmd.const", 32'(ERR), 32'd1);
    drive(1, 1, 0, 1, 2, 0, 2'b00);
    cycle("no_operands");

    drive(1, 1, 0, 'h10, 'h20, 0, 2'b11);
    cycle("pre_reset");
    drive(1, 1, 9, 7, 7, 0, 2'b11);
    cycle("pre_reset_mul");
    #3;
    RST = 1'b0;
    exp_q = zero_exp();
    pend = 0;
    #1;
    check_outputs("async_reset");
    @(posedge clk); #1;
    check_outputs("reset_held");
    RST = 1'b1;
    drive(0, 1, 0, 'h11, 'h22, 0, 2'b11);
    cycle("post_reset_ce0");
    drive(1, 1, 0, 'h11, 'h22, 0, 2'b11);
    cycle("post_reset_first");
    check_val("post_reset_first.const", 32'(RES), 32'h33);

    for (int unsigned i = 0; i < 600; i++) begin
      int unsigned sel;
      int b;
      bit [1:0] iv;
      sel = $urandom_range(0, 7);
      iv  = (sel < 5) ? 2'b11 : 2'(sel);
      b   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 255)), b, 1'($urandom_range(0, 1)), iv);
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
